multi_seg_loader_fsm: RTL
=========================

Name: multi_seg_loader_fsm

Overview:
Boot/run controller that supersedes the single-program client FSM. It drives one generic AXI-lite command port, and the AXI master adapter converts that port into bus transactions. It loads NUM_SEGS memory segments over the AXI UART-lite, then runs the processor until it signals done, then reports completion over UART. Segment count, base addresses, tags, data width and UART map are all parameters. The block has explicit valid/ready handshakes, partial-word strobes and sticky error handling.

Parameters:
DATAW, 32, bus data width; a multiple of 8; BYTES = DATAW/8.
ADDRW, 32, bus address width.
NUM_SEGS, 2, number of segments loaded in order 0..NUM_SEGS-1.
SEG_BASE, {32'h0001_0000, 32'h0000_0000}, packed NUM_SEGS*ADDRW; segment i base = SEG_BASE[i*ADDRW +: ADDRW].
SEG_TAG, {8'haa, 8'h99}, packed NUM_SEGS*8; request byte sent before segment i.
DONE_TAG, 8'hbb, byte sent after execution finishes.
UART_BASE, 32'h4060_0000, UART-lite base; RX = +0x0, TX = +0x4, STAT = +0x8 (bit0 rx_valid, bit3 tx_full).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; sampled only in IDLE.
cmd_valid  out  1  command request.
cmd_ready  in  1  adapter accepts the command.
cmd_write  out  1  1 = write, 0 = read.
cmd_addr  out  ADDRW  byte address.
cmd_wdata  out  DATAW  write data.
cmd_wstrb  out  BYTES  byte strobes; all 0 for reads.
rsp_valid  in  1  response for the single outstanding command.
rsp_rdata  in  DATAW  read data.
rsp_error  in  1  SLVERR/DECERR qualifier of rsp_valid.
processor_enable  out  1  processor run enable.
proc_done  in  1  level; processor halted.
busy  out  1  high in every state except IDLE, HALT, ERR.
seg_idx  out  $clog2(NUM_SEGS+1)  current segment.
error  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, cmd_wstrb=0, processor_enable=0, seg_idx=0, error=0. All counters and the pack register clear. Deassertion takes effect on the next clk edge.
- Command handshake:
  - At most one command is outstanding.
  - cmd_* stay stable while cmd_valid=1 and !cmd_ready.
  - cmd_valid drops in the cycle after acceptance (valid&ready).
  - The FSM then waits for rsp_valid. rsp_valid arriving in the same cycle as acceptance is illegal.
  - rsp_valid & rsp_error → ERR in any state: error=1, processor_enable=0, cmd_valid=0. ERR is terminal.
- UART TX procedure (SEND b): read STAT; if bit3=1, re-poll. Otherwise write b to TX with wstrb = BYTES'(1).
- UART RX procedure (RECV): read STAT; if bit0=0, re-poll. Otherwise read RX; the byte is rsp_rdata[7:0].
- States, each performing the listed operation, with transitions:
  - IDLE → TAG on start.
  - TAG: SEND SEG_TAG[seg_idx] → LEN.
  - LEN: RECV 4 bytes, little-endian, into 32-bit len. If len==0 → NEXT; else → DATA with off=0, pack cleared.
  - DATA: RECV one byte and place it in pack lane k = off mod BYTES. → WRITE if k==BYTES-1 or off==len-1; else off++ and stay in DATA.
  - WRITE: write pack to SEG_BASE[seg_idx] + (off & ~(BYTES-1)). wstrb has lanes 0..k set (a partial last word carries only the valid lanes). After rsp: if off==len-1 → NEXT; else off++, clear pack → DATA.
  - NEXT: seg_idx++. → TAG if seg_idx < NUM_SEGS; else → EXEC.
  - EXEC: processor_enable=1 from the cycle after entry. When proc_done=1, processor_enable drops on the same edge as the move to DONE.
  - DONE: SEND DONE_TAG → HALT.
  - HALT: idle; start restarts from TAG with seg_idx=0 and error unchanged.
- Address arithmetic is modulo 2^ADDRW with no bounds check. len is unsigned; len up to 2^32-1 is legal.
- proc_done outside EXEC is ignored. start outside IDLE/HALT is ignored.
- Reset mid-transaction abandons the outstanding command. The adapter is reset by the same rst.

Test Plan:
- DATAW=32, NUM_SEGS=2, adapter always ready, UART model supplies len=6 then bytes 01..06 for seg0, len=0 for seg1 → TX sees 0x99 then 0xaa. Writes are (0x0000_0000, 0x04030201, 4'b1111) and (0x0000_0004, 0x00000605, 4'b0011). Then EXEC, proc_done, TX 0xbb, state HALT.
- STAT returns tx_full=1 three times, then 0 → exactly 4 STAT reads before the TX write; RX polling with rx_valid=0 twice → no RX read until bit0=1.
- cmd_ready held low 5 cycles with random stalls → cmd_addr/wdata/wstrb remain stable and no command is duplicated or dropped.
- rsp_error=1 on the second payload write → error=1, busy=0, no further cmd_valid; start is ignored until reset.
- DATAW=64, len=9 → first write has wstrb 8'hff; second write is at offset 8 with wstrb 8'h01.
- rst asserted while cmd_valid=1 in DATA → all outputs are at reset values asynchronously, before the next clk edge; a subsequent start reloads from seg0.

Source files
------------

// File: rtl/multi_seg_loader_fsm.sv
// Boot/run controller: loads NUM_SEGS segments over a UART-lite through one
// single-outstanding command port, runs the processor, then reports completion.
module multi_seg_loader_fsm #(
   parameter int                        DATAW     = 32,
   parameter int                        ADDRW     = 32,
   parameter int                        NUM_SEGS  = 2,
   parameter logic [NUM_SEGS*ADDRW-1:0] SEG_BASE  = {32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_SEGS*8-1:0]     SEG_TAG   = {8'haa, 8'h99},
   parameter logic [7:0]                DONE_TAG  = 8'hbb,
   parameter logic [ADDRW-1:0]          UART_BASE = 32'h4060_0000,
   localparam int                       BYTES     = DATAW / 8,
   localparam int                       SW        = $clog2(NUM_SEGS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic             cmd_write,
   output logic [ADDRW-1:0] cmd_addr,
   output logic [DATAW-1:0] cmd_wdata,
   output logic [BYTES-1:0] cmd_wstrb,
   input  logic             rsp_valid,
   input  logic [DATAW-1:0] rsp_rdata,
   input  logic             rsp_error,
   output logic             processor_enable,
   input  logic             proc_done,
   output logic             busy,
   output logic [SW-1:0]    seg_idx,
   output logic             error
);

   typedef enum logic [3:0] {
      S_IDLE, S_TAG, S_LEN, S_DATA, S_WRITE, S_NEXT, S_EXEC, S_DONE, S_HALT, S_ERR
   } state_t;

   // UART procedures first poll STAT, then perform the transfer itself
   typedef enum logic {PH_STAT, PH_XFER} phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             cmd_write_q, cmd_write_d;
   logic [ADDRW-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATAW-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [BYTES-1:0] cmd_wstrb_q, cmd_wstrb_d;
   logic             wait_q, wait_d;
   logic             pe_q, pe_d;
   logic             err_q, err_d;
   logic [31:0]      len_q, len_d;
   logic [31:0]      off_q, off_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [DATAW-1:0] pack_q, pack_d;
   logic [SW-1:0]    seg_q, seg_d;

   logic [SW-1:0]    seg_inc;
   logic [ADDRW-1:0] seg_base, req_addr;
   logic [7:0]       seg_tag, rx_byte;
   logic [31:0]      lane;
   logic [BYTES-1:0] lane_strb, req_strb;
   logic [DATAW-1:0] req_wdata;
   logic             req_write, need_cmd, last_byte, lane_full;
   logic             rdata_unused;

   assign rx_byte      = rsp_rdata[7:0];
   assign rdata_unused = ^rsp_rdata[DATAW-1:8];
   assign seg_inc      = seg_q + SW'(1);
   assign lane         = off_q % 32'(BYTES);
   assign lane_full    = (lane == 32'(BYTES - 1));
   assign last_byte    = (off_q == len_q - 32'd1);
   assign need_cmd     = (state_q == S_TAG) || (state_q == S_LEN) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_DONE);

   always_comb begin
      seg_base = '0;
      seg_tag  = '0;
      for (int i = 0; i < NUM_SEGS; i++) begin
         if (seg_q == SW'(i)) begin
            seg_base = SEG_BASE[i*ADDRW +: ADDRW];
            seg_tag  = SEG_TAG[i*8 +: 8];
         end
      end
      lane_strb = '0;
      for (int i = 0; i < BYTES; i++) begin
         lane_strb[i] = (32'(i) <= lane);
      end
   end

   // Command the current state wants issued; latched only when cmd_valid rises
   always_comb begin
      req_write = 1'b0;
      req_addr  = UART_BASE + ADDRW'(8);
      req_wdata = '0;
      req_strb  = '0;
      case (state_q)
         S_TAG, S_DONE: begin
            if (phase_q == PH_XFER) begin
               req_write = 1'b1;
               req_addr  = UART_BASE + ADDRW'(4);
               req_wdata = DATAW'((state_q == S_TAG) ? seg_tag : DONE_TAG);
               req_strb  = BYTES'(1);
            end
         end
         S_LEN, S_DATA: begin
            if (phase_q == PH_XFER) req_addr = UART_BASE;
         end
         S_WRITE: begin
            req_write = 1'b1;
            req_addr  = seg_base + ADDRW'(off_q & ~32'(BYTES - 1));
            req_wdata = pack_q;
            req_strb  = lane_strb;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cmd_valid_d = cmd_valid_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_wstrb_d = cmd_wstrb_q;
      wait_d      = wait_q;
      pe_d        = pe_q;
      err_d       = err_q;
      len_d       = len_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      pack_d      = pack_q;
      seg_d       = seg_q;

      if (rsp_valid && rsp_error) begin
         state_d     = S_ERR;
         err_d       = 1'b1;
         pe_d        = 1'b0;
         cmd_valid_d = 1'b0;
         wait_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state_d = S_TAG;
                  phase_d = PH_STAT;
                  seg_d   = '0;
               end
            end
            S_NEXT: begin
               seg_d   = seg_inc;
               phase_d = PH_STAT;
               state_d = (seg_inc < SW'(NUM_SEGS)) ? S_TAG : S_EXEC;
            end
            S_EXEC: begin
               if (proc_done) begin
                  pe_d    = 1'b0;
                  state_d = S_DONE;
                  phase_d = PH_STAT;
               end else begin
                  pe_d = 1'b1;
               end
            end
            default: begin
               if (!need_cmd) begin
                  state_d = state_q;
               end else if (cmd_valid_q) begin
                  if (cmd_ready) begin
                     cmd_valid_d = 1'b0;
                     wait_d      = 1'b1;
                  end
               end else if (wait_q) begin
                  if (rsp_valid) begin
                     wait_d = 1'b0;
                     case (state_q)
                        S_TAG, S_DONE: begin
                           if (phase_q == PH_STAT) begin
                              if (!rsp_rdata[3]) phase_d = PH_XFER;
                           end else begin
                              phase_d = PH_STAT;
                              if (state_q == S_TAG) begin
                                 state_d = S_LEN;
                                 cnt_d   = '0;
                                 len_d   = '0;
                              end else begin
                                 state_d = S_HALT;
                              end
                           end
                        end
                        S_LEN: begin
                           if (phase_q == PH_STAT) begin
                              if (rsp_rdata[0]) phase_d = PH_XFER;
                           end else begin
                              phase_d = PH_STAT;
                              len_d[{cnt_q, 3'b000} +: 8] = rx_byte;
                              cnt_d = cnt_q + 2'd1;
                              if (cnt_q == 2'd3) begin
                                 if ({rx_byte, len_q[23:0]} == 32'd0) begin
                                    state_d = S_NEXT;
                                 end else begin
                                    state_d = S_DATA;
                                    off_d   = '0;
                                    pack_d  = '0;
                                 end
                              end
                           end
                        end
                        S_DATA: begin
                           if (phase_q == PH_STAT) begin
                              if (rsp_rdata[0]) phase_d = PH_XFER;
                           end else begin
                              phase_d = PH_STAT;
                              for (int i = 0; i < BYTES; i++) begin
                                 if (lane == 32'(i)) pack_d[i*8 +: 8] = rx_byte;
                              end
                              if (lane_full || last_byte) begin
                                 state_d = S_WRITE;
                              end else begin
                                 off_d = off_q + 32'd1;
                              end
                           end
                        end
                        S_WRITE: begin
                           phase_d = PH_STAT;
                           if (last_byte) begin
                              state_d = S_NEXT;
                           end else begin
                              off_d   = off_q + 32'd1;
                              pack_d  = '0;
                              state_d = S_DATA;
                           end
                        end
                        default: ;
                     endcase
                  end
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_write_d = req_write;
                  cmd_addr_d  = req_addr;
                  cmd_wdata_d = req_wdata;
                  cmd_wstrb_d = req_strb;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_STAT;
         cmd_valid_q <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_wstrb_q <= '0;
         wait_q      <= 1'b0;
         pe_q        <= 1'b0;
         err_q       <= 1'b0;
         len_q       <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         pack_q      <= '0;
         seg_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_wstrb_q <= cmd_wstrb_d;
         wait_q      <= wait_d;
         pe_q        <= pe_d;
         err_q       <= err_d;
         len_q       <= len_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         pack_q      <= pack_d;
         seg_q       <= seg_d;
      end
   end

   assign cmd_valid        = cmd_valid_q;
   assign cmd_write        = cmd_write_q;
   assign cmd_addr         = cmd_addr_q;
   assign cmd_wdata        = cmd_wdata_q;
   assign cmd_wstrb        = cmd_wstrb_q;
   assign processor_enable = pe_q;
   assign seg_idx          = seg_q;
   assign error            = err_q;
   assign busy             = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));

endmodule
